// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM vote tally bank.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2,
    CLEAR  = 2'd3
  } poll_state_t;

  // Largest value representable in a w-bit counter (w < 32).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Increment-and-hold counter with synchronous clear and an at-maximum flag.
module sat_counter
  import evm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count holds once it reaches MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == MAX);

endmodule

// File: rtl/vote_tally_bank.sv
// Bank of per-candidate vote counters with a running total, gated by a poll FSM.
module vote_tally_bank
  import evm_pkg::*;
#(
  parameter int unsigned N_CAND = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned IDX_W  = (N_CAND > 1) ? $clog2(N_CAND) : 1,
  parameter int unsigned TOT_W  = CNT_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              open_poll,
  input  logic              close_poll,
  input  logic              clear_req,
  input  logic              vote_valid,
  input  logic [IDX_W-1:0]  vote_idx,
  output logic              vote_accept,
  output logic              vote_reject,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [TOT_W-1:0]  total,
  output logic [N_CAND-1:0] sat,
  output logic [1:0]        poll_state
);

  localparam logic [CNT_W-1:0] PRE_MAX  = CNT_W'(cnt_max(CNT_W) - 32'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  poll_state_t       state_q;
  logic [IDX_W-1:0]  clr_idx_q;
  logic [TOT_W-1:0]  total_q;
  logic [N_CAND-1:0] sat_q;
  logic              vote_accept_q, vote_reject_q;
  logic              rd_valid_q;
  logic [CNT_W-1:0]  rd_data_q;

  logic [CNT_W-1:0]  cnt_w [N_CAND];
  logic [N_CAND-1:0] at_max_w;
  logic [N_CAND-1:0] inc_c;
  logic [N_CAND-1:0] clr_c;
  logic              vote_ok_c, accept_c, reject_c;
  logic              rd_ok_c;
  logic [CNT_W-1:0]  rd_mux_c;

  // A vote is eligible when polling is open and the index names a real entry.
  assign vote_ok_c = (state_q == OPEN) && vote_valid && (32'(vote_idx) < N_CAND);
  assign accept_c  = |inc_c;
  assign reject_c  = vote_valid && !accept_c;
  assign rd_ok_c   = (state_q == CLOSED) && rd_en && (32'(rd_idx) < N_CAND);

  // One counter per candidate; CLEAR walks the entries one per cycle.
  for (genvar k = 0; k < N_CAND; k++) begin : g_cnt
    assign inc_c[k] = vote_ok_c && (vote_idx == IDX_W'(k)) && !at_max_w[k];
    assign clr_c[k] = (state_q == CLEAR) && (clr_idx_q == IDX_W'(k));

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (clr_c[k]),
      .inc_i    (inc_c[k]),
      .cnt_o    (cnt_w[k]),
      .at_max_o (at_max_w[k])
    );
  end

  // Readout multiplexer over the counter bank.
  always_comb begin
    rd_mux_c = '0;
    for (int k = 0; k < N_CAND; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        rd_mux_c = cnt_w[k];
      end
    end
  end

  // Poll FSM plus total, sticky saturation, vote response and read response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      clr_idx_q     <= '0;
      total_q       <= '0;
      sat_q         <= '0;
      vote_accept_q <= 1'b0;
      vote_reject_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      vote_accept_q <= accept_c;
      vote_reject_q <= reject_c;
      rd_valid_q    <= rd_ok_c;
      rd_data_q     <= rd_ok_c ? rd_mux_c : '0;

      if (accept_c) begin
        total_q <= total_q + TOT_W'(1);
      end
      for (int k = 0; k < N_CAND; k++) begin
        if (inc_c[k] && (cnt_w[k] == PRE_MAX)) begin
          sat_q[k] <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
          end else if (open_poll) begin
            state_q <= OPEN;
          end
        end
        OPEN: begin
          if (close_poll) begin
            state_q <= CLOSED;
          end
        end
        CLOSED: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
          end
        end
        CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            total_q   <= '0;
            sat_q     <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vote_accept = vote_accept_q;
  assign vote_reject = vote_reject_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign total       = total_q;
  assign sat         = sat_q;
  assign poll_state  = state_q;

endmodule

// File: tb/tb_vote_tally_bank.sv
// Directed self-checking bench for vote_tally_bank (N_CAND=4, CNT_W=4, IDX_W=3).
module tb_vote_tally_bank;
  import evm_pkg::*;

  localparam int unsigned N_CAND = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TOT_W  = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              open_poll, close_poll, clear_req;
  logic              vote_valid;
  logic [IDX_W-1:0]  vote_idx;
  logic              vote_accept, vote_reject;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [TOT_W-1:0]  total;
  logic [N_CAND-1:0] sat;
  logic [1:0]        poll_state;

  int checks = 0;
  int errors = 0;

  vote_tally_bank #(
    .N_CAND(N_CAND), .CNT_W(CNT_W), .IDX_W(IDX_W), .TOT_W(TOT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .open_poll(open_poll), .close_poll(close_poll), .clear_req(clear_req),
    .vote_valid(vote_valid), .vote_idx(vote_idx),
    .vote_accept(vote_accept), .vote_reject(vote_reject),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .total(total), .sat(sat), .poll_state(poll_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_open();
    open_poll = 1'b1; tick(); open_poll = 1'b0;
  endtask

  task automatic pulse_close();
    close_poll = 1'b1; tick(); close_poll = 1'b0;
  endtask

  task automatic vote(input int idx);
    vote_valid = 1'b1; vote_idx = IDX_W'(idx); tick(); vote_valid = 1'b0;
  endtask

  task automatic read(input int idx);
    rd_en = 1'b1; rd_idx = IDX_W'(idx); tick(); rd_en = 1'b0;
  endtask

  task automatic full_clear();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (N_CAND) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    checks++; if (poll_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", poll_state); end
    checks++; if (total !== 7'd0) begin errors++; $display("FAIL reset_total got %0d exp 0", total); end
    checks++; if (sat !== 4'd0) begin errors++; $display("FAIL reset_sat got %b exp 0000", sat); end
    checks++; if ({vote_accept, vote_reject, rd_valid} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {vote_accept, vote_reject, rd_valid}); end
    checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL reset_rd_data got %0d exp 0", rd_data); end
  endtask

  task automatic test_basic();
    int vidx [4] = '{0, 1, 1, 3};
    int exp_c [4] = '{1, 2, 0, 1};
    pulse_open();
    checks++; if (poll_state !== 2'd1) begin errors++; $display("FAIL basic_open got %0d exp 1", poll_state); end
    for (int i = 0; i < 4; i++) begin
      vote(vidx[i]);
      checks++; if ({vote_accept, vote_reject} !== 2'b10) begin errors++; $display("FAIL basic_vote%0d got %b exp 10", i, {vote_accept, vote_reject}); end
    end
    tick();
    checks++; if ({vote_accept, vote_reject} !== 2'b00) begin errors++; $display("FAIL basic_idle_pulses got %b exp 00", {vote_accept, vote_reject}); end
    pulse_close();
    checks++; if (poll_state !== 2'd2) begin errors++; $display("FAIL basic_closed got %0d exp 2", poll_state); end
    for (int i = 0; i < 4; i++) begin
      read(i);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 4'(exp_c[i])) begin errors++; $display("FAIL basic_read%0d got v=%b d=%0d exp v=1 d=%0d", i, rd_valid, rd_data, exp_c[i]); end
    end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_drop got %b exp 0", rd_valid); end
    checks++; if (total !== 7'd4) begin errors++; $display("FAIL basic_total got %0d exp 4", total); end
    full_clear();
    checks++; if (poll_state !== 2'd0) begin errors++; $display("FAIL basic_cleared got %0d exp 0", poll_state); end
  endtask

  task automatic test_reject();
    vote(2);
    checks++; if ({vote_accept, vote_reject} !== 2'b01) begin errors++; $display("FAIL rej_idle got %b exp 01", {vote_accept, vote_reject}); end
    pulse_open();
    read(0);
    checks++; if (rd_valid !== 1'b0 || rd_data !== 4'd0) begin errors++; $display("FAIL rej_read_open got v=%b d=%0d exp v=0 d=0", rd_valid, rd_data); end
    vote(5);
    checks++; if ({vote_accept, vote_reject} !== 2'b01) begin errors++; $display("FAIL rej_idx5 got %b exp 01", {vote_accept, vote_reject}); end
    vote(4);
    checks++; if ({vote_accept, vote_reject} !== 2'b01) begin errors++; $display("FAIL rej_idx4 got %b exp 01", {vote_accept, vote_reject}); end
    checks++; if (total !== 7'd0) begin errors++; $display("FAIL rej_total got %0d exp 0", total); end
    pulse_close();
    full_clear();
  endtask

  task automatic test_saturation();
    pulse_open();
    for (int i = 1; i <= 15; i++) begin
      vote(2);
      checks++; if (vote_accept !== 1'b1) begin errors++; $display("FAIL sat_vote%0d got accept=%b exp 1", i, vote_accept); end
      if (i == 14) begin
        checks++; if (sat !== 4'b0000) begin errors++; $display("FAIL sat_early got %b exp 0000", sat); end
      end
    end
    checks++; if (sat !== 4'b0100) begin errors++; $display("FAIL sat_set got %b exp 0100", sat); end
    vote(2);
    checks++; if ({vote_accept, vote_reject} !== 2'b01) begin errors++; $display("FAIL sat_16th got %b exp 01", {vote_accept, vote_reject}); end
    checks++; if (total !== 7'd15) begin errors++; $display("FAIL sat_total got %0d exp 15", total); end
    pulse_close();
    read(2);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 4'd15) begin errors++; $display("FAIL sat_read got v=%b d=%0d exp v=1 d=15", rd_valid, rd_data); end
    full_clear();
    checks++; if (sat !== 4'b0000 || total !== 7'd0) begin errors++; $display("FAIL sat_cleared got sat=%b tot=%0d exp 0000/0", sat, total); end
  endtask

  task automatic test_close_same_cycle();
    pulse_open();
    clear_req = 1'b1; open_poll = 1'b1; tick(); clear_req = 1'b0; open_poll = 1'b0;
    checks++; if (poll_state !== 2'd1) begin errors++; $display("FAIL cs_ignore_in_open got %0d exp 1", poll_state); end
    vote_valid = 1'b1; vote_idx = 3'd1; close_poll = 1'b1; tick();
    vote_valid = 1'b0; close_poll = 1'b0;
    checks++; if (vote_accept !== 1'b1 || poll_state !== 2'd2) begin errors++; $display("FAIL cs_vote got acc=%b st=%0d exp acc=1 st=2", vote_accept, poll_state); end
    vote(1);
    checks++; if ({vote_accept, vote_reject} !== 2'b01) begin errors++; $display("FAIL cs_after got %b exp 01", {vote_accept, vote_reject}); end
    read(1);
    checks++; if (rd_data !== 4'd1 || total !== 7'd1) begin errors++; $display("FAIL cs_read got d=%0d tot=%0d exp d=1 tot=1", rd_data, total); end
    full_clear();
  endtask

  task automatic test_clear();
    int vidx [6] = '{0, 0, 0, 2, 2, 3};
    int exp_c [4] = '{3, 0, 2, 1};
    pulse_open();
    for (int i = 0; i < 6; i++) vote(vidx[i]);
    pulse_close();
    for (int i = 0; i < 4; i++) begin
      read(i);
      checks++; if (rd_data !== 4'(exp_c[i])) begin errors++; $display("FAIL clr_pre_read%0d got %0d exp %0d", i, rd_data, exp_c[i]); end
    end
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    checks++; if (total !== 7'd6) begin errors++; $display("FAIL clr_total_held got %0d exp 6", total); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (poll_state !== 2'd3) begin errors++; $display("FAIL clr_state_c%0d got %0d exp 3", c, poll_state); end
      tick();
    end
    checks++; if (poll_state !== 2'd0) begin errors++; $display("FAIL clr_done got %0d exp 0", poll_state); end
    checks++; if (total !== 7'd0 || sat !== 4'd0) begin errors++; $display("FAIL clr_tot_sat got tot=%0d sat=%b exp 0/0000", total, sat); end
    pulse_open();
    pulse_close();
    for (int i = 0; i < 4; i++) begin
      read(i);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 4'd0) begin errors++; $display("FAIL clr_read%0d got v=%b d=%0d exp v=1 d=0", i, rd_valid, rd_data); end
    end
    full_clear();
  endtask

  task automatic test_reset_mid_clear();
    pulse_open();
    vote(3); vote(3);
    pulse_close();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (poll_state !== 2'd0) begin errors++; $display("FAIL rmc_state got %0d exp 0", poll_state); end
    checks++; if (total !== 7'd0 || sat !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 4'd0 || vote_accept !== 1'b0 || vote_reject !== 1'b0) begin
      errors++; $display("FAIL rmc_outputs got tot=%0d sat=%b rv=%b rd=%0d acc=%b rej=%b exp all 0", total, sat, rd_valid, rd_data, vote_accept, vote_reject);
    end
    pulse_open();
    vote(0);
    checks++; if (total !== 7'd1) begin errors++; $display("FAIL rmc_total got %0d exp 1", total); end
    pulse_close();
    read(3);
    checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL rmc_read3 got %0d exp 0", rd_data); end
    read(0);
    checks++; if (rd_data !== 4'd1) begin errors++; $display("FAIL rmc_read0 got %0d exp 1", rd_data); end
  endtask

  initial begin
    rst_n = 1'b0; open_poll = 1'b0; close_poll = 1'b0; clear_req = 1'b0;
    vote_valid = 1'b0; vote_idx = '0; rd_en = 1'b0; rd_idx = '0;
    test_reset();
    test_basic();
    test_reject();
    test_saturation();
    test_close_same_cycle();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_tally_bank.md
Name: vote_tally_bank

Overview:
- Parametrised successor to the 4-bit memory block: a bank of N_CAND per-candidate vote counters plus a running total.
- A poll-control state machine gates every write; counters are readable only once the poll is closed.
- Sits between the ballot input logic and the result display/readout path of the EVM.

Parameters:
- N_CAND, 4, number of candidates / counter entries (2..16).
- CNT_W, 8, width of each candidate counter.
- IDX_W, $clog2(N_CAND) (min 1), width of candidate index buses.
- TOT_W, CNT_W+IDX_W, width of total counter; cannot overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- open_poll  in  1  single-cycle pulse; starts polling.
- close_poll  in  1  single-cycle pulse; ends polling.
- clear_req  in  1  single-cycle pulse; zeroes the bank.
- vote_valid  in  1  a vote is presented this cycle.
- vote_idx  in  IDX_W  candidate being voted for.
- vote_accept  out  1  registered pulse, the vote was counted.
- vote_reject  out  1  registered pulse, the vote was refused.
- rd_en  in  1  read request.
- rd_idx  in  IDX_W  counter to read.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  CNT_W  counter value.
- total  out  TOT_W  sum of accepted votes.
- sat  out  N_CAND  sticky flag per candidate; set when that counter is saturated.
- poll_state  out  2  encoded current state.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): all counters, total, sat, vote_accept, vote_reject, rd_valid and rd_data go to 0; state goes to IDLE. Reset applies from any state, including mid-CLEAR.
- States and encodings: IDLE=0, OPEN=1, CLOSED=2, CLEAR=3.
- Transitions:
  - IDLE: open_poll -> OPEN; clear_req -> CLEAR.
  - OPEN: close_poll -> CLOSED. open_poll and clear_req are ignored.
  - CLOSED: clear_req -> CLEAR. open_poll and close_poll are ignored.
  - CLEAR: zeroes entry k on the k-th cycle, for k = 0..N_CAND-1. After the last entry it also zeroes total and sat, then returns to IDLE. All inputs except rst_n are ignored while in CLEAR.
- Control priority in the same cycle: clear_req > close_poll > open_poll, applied only where the transition is legal.
- Vote handling (evaluated on the state held during the cycle):
  - Accept when state==OPEN, vote_valid=1, vote_idx<N_CAND and counter[vote_idx] < 2^CNT_W-1.
  - On accept: counter +1, total +1, vote_accept=1 on the next cycle.
  - Any other case with vote_valid=1 gives vote_reject=1 on the next cycle; no counter changes.
  - A vote presented in the same cycle as close_poll is still evaluated as OPEN.
- Saturation:
  - The increment that brings a counter to 2^CNT_W-1 is accepted and sets sat[idx] in the same edge.
  - Later votes for that candidate are rejected; the counter holds at maximum.
  - sat is cleared only by reset or by CLEAR.
- vote_accept and vote_reject are mutually exclusive and are 0 whenever vote_valid was 0.
- Reads:
  - Served only in CLOSED with rd_en=1 and rd_idx<N_CAND.
  - rd_valid=1 and rd_data=counter[rd_idx] one cycle later.
  - Otherwise rd_valid=0 and rd_data=0. Reads during OPEN are refused so partial results stay secret.
- total and poll_state are always visible. Counters are plain flops, not inferred RAM.

Decomposition:
- Package evm_pkg holds:
  - the poll_state_t enum (IDLE, OPEN, CLOSED, CLEAR) with the fixed encodings above;
  - a CNT_MAX helper function.
- One sub-module is natural: sat_counter (CNT_W-bit increment-and-hold counter with sync clear and a sat output). Instantiate it N_CAND times in a generate loop.

Test Plan (N_CAND=4, CNT_W=4):
1. Reset, open_poll, votes idx 0,1,1,3 -> four vote_accept pulses. Then close_poll, read idx 0..3 -> rd_data 1,2,0,1 with 1-cycle latency; total=4.
2. Vote idx 2 while IDLE, rd_en in OPEN, vote_idx=5 in OPEN (with N_CAND=4 at IDX_W=3 bench variant) -> vote_reject each time; rd_valid=0; total unchanged.
3. 15 votes for idx 2 -> all accepted, sat[2]=1 on the 15th; 16th vote -> vote_reject, counter stays 15, total=15.
4. Vote idx 1 in the same cycle as close_poll -> accepted, state=CLOSED next cycle. A further vote -> rejected.
5. CLOSED with counts 3,0,2,1, then clear_req -> state=CLEAR for 4 cycles then IDLE; after reopen and close, reads return 0,0,0,0; total=0, sat=0.
6. rst_n=0 for one edge during CLEAR cycle 2 -> state IDLE, all outputs 0. Then open_poll followed by one vote idx 0 -> total=1.
